bram_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the dual-port block RAM. It parses framed bytes from a serial receiver (sync byte, start address, word count, little-endian 16-bit data, checksum) and drives one BRAM write port. The CPU can then be released from the loaded image. Data words are written as they arrive; the checksum only reports success or error and never rolls back writes.

---
 rtl/bram_loader.sv | 178 +++++++++++++++++
 tb/tb_bram_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_loader
//  Purpose  : Framed byte-stream boot loader driving one BRAM write port.
//             Frame: sync, adr[7:0], adr[15:8], cnt[7:0], cnt[15:8],
//             cnt x {lo, hi} data words, 8-bit sum of the data bytes.
//             Words are written as they arrive; the checksum only reports.
//  Revision : 1.0  initial release
// ============================================================================
module bram_loader #(
  parameter int         adr_width = 11,
  parameter logic [7:0] sync_byte = 8'hA5,
  parameter int         timeout   = 1000000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_stb,
  output logic [adr_width-1:0] mem_a,
  output logic [15:0]          mem_do,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam logic [16:0] c_depth  = 17'd1 << adr_width;
  localparam logic [19:0] c_tmo    = 20'(timeout);
  localparam bit          c_tmo_en = (timeout != 0);

  localparam logic [1:0] c_code_ok   = 2'b00;
  localparam logic [1:0] c_code_csum = 2'b01;
  localparam logic [1:0] c_code_rng  = 2'b10;
  localparam logic [1:0] c_code_tmo  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADR_L = 3'd1,
    S_ADR_H = 3'd2,
    S_CNT_L = 3'd3,
    S_CNT_H = 3'd4,
    S_DAT_L = 3'd5,
    S_DAT_H = 3'd6,
    S_CSUM  = 3'd7
  } state_t;

  state_t                 state_q;
  logic [15:0]            adr_q;
  logic [7:0]             cnt_lo_q;
  logic [15:0]            cnt_q;
  logic [adr_width-1:0]   ptr_q;
  logic [7:0]             lo_q;
  logic [7:0]             csum_q;
  logic [19:0]            tmo_q;
  logic [19:0]            tmo_d;

  logic [15:0]            w_cnt;
  logic [16:0]            w_end;
  logic                   w_adr_oob;
  logic                   w_range_bad;
  logic                   w_tmo_hit;

  // Header decode on the CNT_H byte and idle-cycle timeout detection.
  always_comb begin
    w_cnt       = {rx_data, cnt_lo_q};
    w_end       = {1'b0, adr_q} + {1'b0, w_cnt};
    w_adr_oob   = (adr_q >> adr_width) != 16'd0;
    w_range_bad = w_adr_oob || (w_end > c_depth);
    tmo_d       = tmo_q + 20'd1;
    // The expiry cycle is the strobe-free cycle in which the count reaches timeout.
    w_tmo_hit   = c_tmo_en && (tmo_d == c_tmo);
  end

  // Frame parser FSM with registered BRAM port and status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      cnt_lo_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      mem_a    <= '0;
      mem_do   <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= c_code_ok;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      if (state_q == S_IDLE || rx_stb) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_d;
      end

      if (rx_stb) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == sync_byte) begin
              state_q <= S_ADR_L;
              busy    <= 1'b1;
              csum_q  <= '0;
            end
          end
          S_ADR_L: begin
            adr_q[7:0] <= rx_data;
            state_q    <= S_ADR_H;
          end
          S_ADR_H: begin
            adr_q[15:8] <= rx_data;
            state_q     <= S_CNT_L;
          end
          S_CNT_L: begin
            cnt_lo_q <= rx_data;
            state_q  <= S_CNT_H;
          end
          S_CNT_H: begin
            if (w_range_bad) begin
              // Reject the whole frame; trailing bytes fall through as IDLE traffic.
              err_code <= c_code_rng;
              err      <= 1'b1;
              busy     <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              ptr_q   <= adr_q[adr_width-1:0];
              cnt_q   <= w_cnt;
              state_q <= (w_cnt == 16'd0) ? S_CSUM : S_DAT_L;
            end
          end
          S_DAT_L: begin
            lo_q    <= rx_data;
            csum_q  <= csum_q + rx_data;
            state_q <= S_DAT_H;
          end
          S_DAT_H: begin
            mem_we  <= 1'b1;
            mem_a   <= ptr_q;
            mem_do  <= {rx_data, lo_q};
            ptr_q   <= ptr_q + adr_width'(1);
            cnt_q   <= cnt_q - 16'd1;
            csum_q  <= csum_q + rx_data;
            state_q <= (cnt_q == 16'd1) ? S_CSUM : S_DAT_L;
          end
          S_CSUM: begin
            if (rx_data == csum_q) begin
              err_code <= c_code_ok;
              done     <= 1'b1;
            end else begin
              err_code <= c_code_csum;
              err      <= 1'b1;
            end
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end else if (state_q != S_IDLE && w_tmo_hit) begin
        err_code <= c_code_tmo;
        err      <= 1'b1;
        busy     <= 1'b0;
        state_q  <= S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_loader
//  Purpose  : Scoreboard bench for bram_loader (adr_width=11, timeout=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bram_loader;

  localparam int c_aw    = 11;
  localparam int c_depth = 2048;
  localparam int c_tmo   = 16;

  logic             sys_clk;
  logic             sys_rst;
  logic [7:0]       rx_data;
  logic             rx_stb;
  logic [c_aw-1:0]  mem_a;
  logic [15:0]      mem_do;
  logic             mem_we;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  bram_loader #(
    .adr_width (c_aw),
    .sync_byte (8'hA5),
    .timeout   (c_tmo)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx_data  (rx_data),
    .rx_stb   (rx_stb),
    .mem_a    (mem_a),
    .mem_do   (mem_do),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Event kinds: 0 = write (a, d), 1 = done, 2 = err (d = code)
  typedef struct {
    int kind;
    int a;
    int d;
  } ev_t;

  ev_t         sb[$];
  logic [15:0] fw[$];
  logic [15:0] ref_mem [0:c_depth-1];
  logic [15:0] tb_mem  [0:c_depth-1];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endfunction

  function automatic void push_ev(input int kind, input int a, input int d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    sb.push_back(e);
  endfunction

  function automatic void expect_ev(input int kind, input int a, input int d);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d a=%0h d=%0h, expected no event", kind, a, d);
      return;
    end
    e = sb.pop_front();
    if (e.kind == kind && e.a == a && e.d == d) n_pass++;
    else $display("FAIL event: got kind=%0d a=%0h d=%0h, expected kind=%0d a=%0h d=%0h",
                  kind, a, d, e.kind, e.a, e.d);
  endfunction

  // Monitor: every DUT output event is popped against the scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (mem_we) begin
        tb_mem[mem_a] = mem_do;
        expect_ev(0, int'(mem_a), int'(mem_do));
      end
      if (done) begin
        expect_ev(1, 0, 0);
        chk("done_code", int'(err_code), 0);
        chk("done_busy", int'(busy), 0);
      end
      if (err) begin
        expect_ev(2, 0, int'(err_code));
        chk("err_busy", int'(busy), 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(posedge sys_clk); #1;
    rx_stb  = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_we",   int'(mem_we),   0);
    chk("rst_mem_a",    int'(mem_a),    0);
    chk("rst_mem_do",   int'(mem_do),   0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_done",     int'(done),     0);
    chk("rst_err",      int'(err),      0);
    chk("rst_err_code", int'(err_code), 0);
  endtask

  // Reference model: predicts a whole frame's outcome from its fields.
  // trunc >= 0 sends only that many bytes (then the line goes silent);
  // long_idx selects a byte after which a 15-cycle gap is inserted.
  task automatic run_frame(input int adr, input int cnt, input bit bad,
                           input int gap_max, input int trunc, input int long_idx);
    logic [7:0] b[$];
    int  sum;
    int  n_send;
    int  nw;
    bit  rng_bad;
    bit  expect_tmo;
    sum = 0;
    expect_tmo = 1'b0;
    b.push_back(8'hA5);
    b.push_back(8'(adr));
    b.push_back(8'(adr >> 8));
    b.push_back(8'(cnt));
    b.push_back(8'(cnt >> 8));
    for (int i = 0; i < cnt && i < fw.size(); i++) begin
      b.push_back(fw[i][7:0]);
      b.push_back(fw[i][15:8]);
      sum += int'(fw[i][7:0]) + int'(fw[i][15:8]);
    end
    b.push_back(bad ? (8'(sum) ^ 8'h01) : 8'(sum));
    rng_bad = (adr >= c_depth) || (adr + cnt > c_depth);

    if (trunc >= 0 && trunc < 5) begin
      n_send = trunc;
      expect_tmo = 1'b1;
      push_ev(2, 0, 3);
    end else if (rng_bad) begin
      n_send = 5;
      push_ev(2, 0, 2);
    end else begin
      nw = cnt;
      if (trunc >= 0) begin
        n_send = trunc;
        nw = (trunc - 5) / 2;
        if (nw > cnt) nw = cnt;
        expect_tmo = 1'b1;
      end else begin
        n_send = b.size();
      end
      for (int i = 0; i < nw; i++) begin
        push_ev(0, adr + i, int'(fw[i]));
        ref_mem[adr + i] = fw[i];
      end
      if (expect_tmo)  push_ev(2, 0, 3);
      else if (bad)    push_ev(2, 0, 1);
      else             push_ev(1, 0, 0);
    end

    for (int i = 0; i < n_send; i++) begin
      send_byte(b[i]);
      if (i < n_send - 1) idle((i == long_idx) ? (c_tmo - 1) : $urandom_range(0, gap_max));
    end
    idle(expect_tmo ? (c_tmo + 4) : 3);
    chk("sb_drained", sb.size(), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int mism;
    for (int i = 0; i < c_depth; i++) begin
      ref_mem[i] = '0;
      tb_mem[i]  = '0;
    end
    sys_rst = 1'b1;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_vals();
    sys_rst = 1'b0;
    idle(2);

    // Good frame A5 10 00 02 00 34 12 78 56 14
    fw = '{16'h1234, 16'h5678};
    run_frame(16'h0010, 2, 1'b0, 0, -1, -1);
    chk("readback_010", int'(tb_mem[16'h010]), 16'h1234);
    chk("readback_011", int'(tb_mem[16'h011]), 16'h5678);

    // Same frame, checksum byte 15
    run_frame(16'h0010, 2, 1'b1, 0, -1, -1);
    chk("bad_csum_code", int'(err_code), 1);

    // Reset between DAT_L and DAT_H of word 2
    push_ev(0, 16'h040, 16'h1111);
    ref_mem[16'h040] = 16'h1111;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h22);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk_reset_vals();
    sys_rst = 1'b0;
    idle(c_tmo + 4);
    chk("rst_sb_drained", sb.size(), 0);

    // Range boundary with adr_width=11
    run_frame(16'h07FF, 2, 1'b0, 1, -1, -1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);   // trailing bytes ignored in IDLE
    idle(3);
    chk("rng_tail_busy", int'(busy), 0);
    fw = '{16'h55AA};
    run_frame(16'h07FF, 1, 1'b0, 1, -1, -1);
    chk("readback_7ff", int'(tb_mem[16'h7FF]), 16'h55AA);

    // Timeout: A5 10 then silence
    push_ev(2, 0, 3);
    send_byte(8'hA5);
    chk("busy_after_sync", int'(busy), 1);
    send_byte(8'h10);
    idle(c_tmo - 1);
    chk("tmo_not_yet", sb.size(), 1);
    chk("tmo_busy_before", int'(busy), 1);
    idle(1);
    chk("tmo_err_pulse", int'(err), 1);
    chk("tmo_code", int'(err_code), 3);
    idle(3);
    chk("tmo_sb_drained", sb.size(), 0);
    chk("tmo_busy_low", int'(busy), 0);
    fw = '{16'hCAFE, 16'h0102};
    run_frame(16'h0100, 2, 1'b0, 2, -1, -1);
    // A byte landing in the expiry cycle keeps the frame alive
    fw = '{16'hBEEF};
    run_frame(16'h0020, 1, 1'b0, 0, -1, 1);

    // Noise in IDLE, then an empty frame
    send_byte(8'h00); chk("noise_busy0", int'(busy), 0);
    send_byte(8'hFF); chk("noise_busy1", int'(busy), 0);
    send_byte(8'h5A); chk("noise_busy2", int'(busy), 0);
    idle(2);
    fw.delete();
    run_frame(16'h0100, 0, 1'b0, 0, -1, -1);

    // Back-to-back strobes over 64 words
    fw.delete();
    for (int i = 0; i < 64; i++) fw.push_back(16'($urandom));
    run_frame(16'h0200, 64, 1'b0, 0, -1, -1);

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      int kind;
      int adr;
      int cnt;
      int nn;
      int trunc;
      logic [7:0] nb;
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
        idle($urandom_range(0, 1));
      end
      kind = $urandom_range(0, 9);
      cnt  = $urandom_range(0, 6);
      fw.delete();
      for (int i = 0; i < cnt; i++) fw.push_back(16'($urandom));
      if (kind == 0) begin
        adr = c_depth - $urandom_range(1, 4);
        cnt = (c_depth - adr) + $urandom_range(1, 3);
        run_frame(adr, cnt, 1'b0, 2, -1, -1);
      end else if (kind == 1) begin
        adr = $urandom_range(c_depth, 65535);
        run_frame(adr, cnt, 1'b0, 2, -1, -1);
      end else if (kind == 2) begin
        adr   = $urandom_range(0, c_depth - cnt);
        trunc = $urandom_range(1, 5 + 2 * cnt);
        run_frame(adr, cnt, 1'b0, 2, trunc, -1);
      end else begin
        adr = $urandom_range(0, c_depth - cnt);
        run_frame(adr, cnt, ($urandom_range(0, 3) == 0), 3, -1, -1);
      end
    end

    mism = 0;
    for (int i = 0; i < c_depth; i++) begin
      if (tb_mem[i] !== ref_mem[i]) mism++;
    end
    chk("bram_readback_mismatches", mism, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
